// File: rtl/md_iter_unit.sv
// md_iter_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Multiplies latch the full product at issue and commit after MUL_CYCLES
// busy cycles. Divides run a restoring loop, one quotient bit per cycle,
// followed by a single sign-fix cycle. HI/LO only change at commit edges
// (or at the accepting edge of MTHI/MTLO).
module md_iter_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2      = 2 * WIDTH;
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MUL   = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_DIV   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // Accumulate modes for multiply-class commits
    localparam logic [1:0] MM_SET = 2'd0;
    localparam logic [1:0] MM_ADD = 2'd1;
    localparam logic [1:0] MM_SUB = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic              busy_r;
    logic [WIDTH-1:0]  hi_r;
    logic [WIDTH-1:0]  lo_r;
    logic [W2-1:0]     prod_r;
    logic [1:0]        mul_mode_r;
    logic [WIDTH-1:0]  rem_r;
    logic [WIDTH-1:0]  quo_r;
    logic [WIDTH-1:0]  dsr_r;
    logic              neg_q_r;
    logic              neg_r_r;

    logic              is_mul_s;
    logic              is_div_s;
    logic              is_mthi_s;
    logic              is_mtlo_s;
    logic              op_signed_s;
    logic [1:0]        mul_mode_s;
    logic [W2-1:0]     ext_a_s;
    logic [W2-1:0]     ext_b_s;
    logic [W2-1:0]     product_s;
    logic              b_zero_s;
    logic              neg_a_s;
    logic              neg_b_s;
    logic [WIDTH-1:0]  abs_a_s;
    logic [WIDTH-1:0]  abs_b_s;
    logic [WIDTH:0]    trial_s;
    logic [W2-1:0]     hilo_s;
    logic [W2-1:0]     mul_res_s;
    logic [WIDTH-1:0]  quo_fix_s;
    logic [WIDTH-1:0]  rem_fix_s;

    // Decode the op field into operation class, signedness and accumulate mode
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_mthi_s   = 1'b0;
        is_mtlo_s   = 1'b0;
        op_signed_s = 1'b0;
        mul_mode_s  = MM_SET;
        case (op)
            4'd1:    begin is_mul_s = 1'b1; op_signed_s = 1'b1; end
            4'd2:    begin is_mul_s = 1'b1; end
            4'd3:    begin is_div_s = 1'b1; op_signed_s = 1'b1; end
            4'd4:    begin is_div_s = 1'b1; end
            4'd5:    begin is_mul_s = 1'b1; op_signed_s = 1'b1; mul_mode_s = MM_ADD; end
            4'd6:    begin is_mul_s = 1'b1; mul_mode_s = MM_ADD; end
            4'd7:    begin is_mul_s = 1'b1; op_signed_s = 1'b1; mul_mode_s = MM_SUB; end
            4'd8:    begin is_mul_s = 1'b1; mul_mode_s = MM_SUB; end
            4'd9:    begin is_mthi_s = 1'b1; end
            4'd10:   begin is_mtlo_s = 1'b1; end
            default: begin is_mul_s = 1'b0; end
        endcase
    end

    // Operand preparation: extended product for multiplies, magnitudes and
    // sign flags for divides. A zero divisor keeps the raw dividend and no
    // sign fix, so the restoring loop yields all-ones / raw dividend.
    always_comb begin
        if (op_signed_s) begin
            ext_a_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
            ext_b_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
        end else begin
            ext_a_s = {ZERO_W, src_a};
            ext_b_s = {ZERO_W, src_b};
        end
        product_s = ext_a_s * ext_b_s;
        b_zero_s  = (src_b == ZERO_W);
        neg_a_s   = op_signed_s & src_a[WIDTH-1] & ~b_zero_s;
        neg_b_s   = op_signed_s & src_b[WIDTH-1];
        abs_a_s   = neg_a_s ? (ZERO_W - src_a) : src_a;
        abs_b_s   = neg_b_s ? (ZERO_W - src_b) : src_b;
    end

    // Restoring step and commit values derived from the scratch registers
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dsr_r};
        hilo_s  = {hi_r, lo_r};
        case (mul_mode_r)
            MM_ADD:  mul_res_s = hilo_s + prod_r;
            MM_SUB:  mul_res_s = hilo_s - prod_r;
            default: mul_res_s = prod_r;
        endcase
        quo_fix_s = neg_q_r ? (ZERO_W - quo_r) : quo_r;
        rem_fix_s = neg_r_r ? (ZERO_W - rem_r) : rem_r;
    end

    // Control FSM with HI/LO, busy and all scratch state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            busy_r     <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            prod_r     <= {W2{1'b0}};
            mul_mode_r <= MM_SET;
            rem_r      <= ZERO_W;
            quo_r      <= ZERO_W;
            dsr_r      <= ZERO_W;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (start && !cancel) begin
                        if (is_mthi_s) hi_r <= src_a;
                        if (is_mtlo_s) lo_r <= src_a;
                        if (is_mul_s) begin
                            prod_r     <= product_s;
                            mul_mode_r <= mul_mode_s;
                            cnt_r      <= CNT_MUL;
                            busy_r     <= 1'b1;
                            state_r    <= ST_MUL;
                        end else if (is_div_s) begin
                            quo_r   <= abs_a_s;
                            dsr_r   <= abs_b_s;
                            rem_r   <= ZERO_W;
                            neg_q_r <= neg_a_s ^ neg_b_s;
                            neg_r_r <= neg_a_s;
                            cnt_r   <= CNT_DIV;
                            busy_r  <= 1'b1;
                            state_r <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_ZERO) begin
                        {hi_r, lo_r} <= mul_res_s;
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DIV: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        if (!trial_s[WIDTH]) begin
                            rem_r <= trial_s[WIDTH-1:0];
                            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
                            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                        end
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_FIX;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        lo_r <= quo_fix_s;
                        hi_r <= rem_fix_s;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign stall_req = busy_r | (start & (op >= 4'd1) & (op <= 4'd8));

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed testbench for md_iter_unit (WIDTH=32, MUL_CYCLES=5).
module tb_md_iter_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    int n;

    md_iter_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one accepting edge, then scramble operands.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        op    = 4'd0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h1234_5678;
    endtask

    // Count busy cycles from now until busy drops, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 4'd0;
        src_a  = 32'd0;
        src_b  = 32'd0;
        cancel = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_stall", {63'd0, stall_req}, 64'd0);

        // MULT -2 * 3 with stall_req in the issue cycle
        start = 1'b1; op = 4'd1; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
        #1;
        chk("mult_stall_issue", {63'd0, stall_req}, 64'd1);
        step();
        start = 1'b0; op = 4'd0; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
        chk("mult_hold_lo", {32'd0, lo}, 64'd0);
        wait_idle(n);
        chk("mult_busy_cycles", 64'(n), 64'd5);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        // MTLO / MTHI then MADDU 1*1 and MSUB 1*1
        issue(4'd10, 32'hFFFF_FFFF, 32'd0);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        issue(4'd9, 32'd0, 32'd0);
        chk("mt_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("mt_hi", {32'd0, hi}, 64'd0);
        issue(4'd6, 32'd1, 32'd1);
        wait_idle(n);
        chk("maddu_busy_cycles", 64'(n), 64'd5);
        chk("maddu_hi", {32'd0, hi}, 64'd1);
        chk("maddu_lo", {32'd0, lo}, 64'd0);
        issue(4'd7, 32'd1, 32'd1);
        wait_idle(n);
        chk("msub_hi", {32'd0, hi}, 64'd0);
        chk("msub_lo", {32'd0, lo}, 64'hFFFF_FFFF);

        // DIV -7 / 2 and DIVU of the same bit patterns
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_hold_hi", {32'd0, hi}, 64'd0);
        wait_idle(n);
        chk("div_busy_cycles", 64'(n), 64'd33);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("divu_busy_cycles", 64'(n), 64'd33);
        chk("divu_lo", {32'd0, lo}, 64'h7FFF_FFFC);
        chk("divu_hi", {32'd0, hi}, 64'd1);

        // Signed overflow and divide by zero
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
        chk("div_ovf_hi", {32'd0, hi}, 64'd0);
        issue(4'd4, 32'd5, 32'd0);
        wait_idle(n);
        chk("divu_zero_cycles", 64'(n), 64'd33);
        chk("divu_zero_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("divu_zero_hi", {32'd0, hi}, 64'd5);
        issue(4'd3, 32'hFFFF_FFF9, 32'd0);
        wait_idle(n);
        chk("div_zero_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("div_zero_hi", {32'd0, hi}, 64'hFFFF_FFF9);

        // Cancel a divide at busy cycle 10
        issue(4'd9, 32'h11, 32'd0);
        issue(4'd10, 32'h22, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        repeat (9) step();
        chk("cancel_busy_before", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_hi", {32'd0, hi}, 64'h11);
        chk("cancel_lo", {32'd0, lo}, 64'h22);
        step();
        chk("cancel_lo_later", {32'd0, lo}, 64'h22);

        // start with cancel in IDLE is ignored
        cancel = 1'b1;
        issue(4'd9, 32'h99, 32'd0);
        cancel = 1'b0;
        chk("cancel_start_hi", {32'd0, hi}, 64'h11);

        issue(4'd1, 32'd3, 32'd4);
        wait_idle(n);
        chk("mult34_busy_cycles", 64'(n), 64'd5);
        chk("mult34_lo", {32'd0, lo}, 64'd12);
        chk("mult34_hi", {32'd0, hi}, 64'd0);

        // Reset in busy cycle 3 of a MULT
        issue(4'd1, 32'd7, 32'd7);
        step();
        step();
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);

        // start while busy is ignored
        issue(4'd1, 32'd2, 32'd3);
        step();
        start = 1'b1; op = 4'd1; src_a = 32'd5; src_b = 32'd5;
        step();
        start = 1'b0; op = 4'd0;
        wait_idle(n);
        chk("ignored_busy_cycles", 64'(n), 64'd3);
        chk("ignored_lo", {32'd0, lo}, 64'd6);
        chk("ignored_hi", {32'd0, hi}, 64'd0);
        step();
        chk("ignored_no_second", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, used by the EX stage for MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO.
- Divide uses an iterative restoring algorithm, one quotient bit per cycle. Multiply uses a programmable-latency pipeline.
- Supports cancel of an in-flight operation on exception/flush.
- EX stage uses `busy` to stall MFHI/MFLO and any new MD op.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_CYCLES, 5, busy cycles for multiply-class ops (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  issue op this cycle
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, others NOP
- src_a  in  WIDTH  rs operand (dividend / multiplicand / MTxx data)
- src_b  in  WIDTH  rt operand (divisor / multiplier)
- cancel  in  1  abort in-flight op
- busy  out  1  registered; high while an op is in flight
- stall_req  out  1  combinational: busy | (start & op in 1..8)
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Reset: hi=0, lo=0, busy=0, state IDLE, counter=0, scratch registers 0. Reset mid-operation aborts the op and clears HI/LO.
- Issue rules:
  - start is accepted only in IDLE with cancel=0.
  - start while busy is ignored; the EX stage must hold it via stall_req.
  - op 0/11-15 with start is a no-op.
- MTHI/MTLO: hi (resp. lo) <= src_a at the accepting edge. busy stays 0. No other state change.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE -> MUL on an accepted op 1,2,5,6,7,8:
  - Latch the 2*WIDTH product (signed for 1,5,7; unsigned for 2,6,8) and load counter=MUL_CYCLES-1.
  - busy=1 for exactly MUL_CYCLES cycles.
  - At the edge ending the last busy cycle, commit:
    - MULT/MULTU: {hi,lo} = product.
    - MADD/MADDU: {hi,lo} += product.
    - MSUB/MSUBU: {hi,lo} -= product.
    - All arithmetic is mod 2^(2*WIDTH).
  - The accumulate uses the {hi,lo} value present at commit time.
- IDLE -> DIV on an accepted op 3,4:
  - Latch |a| and |b| (signed op) or raw a and b (unsigned op). Latch the sign flags. Counter=WIDTH-1.
  - DIV: one restoring step per cycle, WIDTH cycles total, MSB first.
  - DIV -> FIX after the last step.
  - FIX: apply signs. The quotient is negated if sign(a)!=sign(b). The remainder takes the sign of the dividend.
  - Commit lo=quotient, hi=remainder at the edge leaving FIX.
  - busy=1 for WIDTH+1 cycles in total.
- Divide by zero (src_b=0, signed or unsigned): lo = all ones, hi = src_a (raw, unsigned interpretation of the restoring result). Same latency as a normal divide.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0. This falls out of the abs/negate flow and needs no special case.
- While busy, hi and lo hold their pre-op values. Only the commit edge changes them.
- cancel:
  - In MUL/DIV/FIX, the next state is IDLE and busy=0 the next cycle. No commit occurs and HI/LO are unchanged.
  - cancel on the same cycle as the commit edge: cancel wins and there is no commit.
  - cancel with start in IDLE: start is ignored.
- Back-to-back: a new start is accepted in the first cycle busy=0 after a commit.
- Operands are sampled only at the accepting edge. src_a/src_b changes during busy have no effect.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. stall_req=1 in the issue cycle.
- MTLO 0xFFFFFFFF, MTHI 0; then MADDU 1*1 -> after 5 busy cycles hi=0x00000001, lo=0x00000000. Follow with MSUB 1*1 -> hi=0, lo=0xFFFFFFFF.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> busy 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- Preload hi=0x11, lo=0x22; start DIV 100/7; assert cancel at busy cycle 10 -> busy=0 next cycle, hi=0x11, lo=0x22. A new MULT 3*4 issued after that completes with lo=12, hi=0.
- Reset asserted during busy cycle 3 of a MULT -> next cycle busy=0, hi=lo=0. A start issued in the same cycle as busy-high is ignored and the result reflects only the first op.
